// File: rtl/valu_seq_pkg.sv
// Shared definitions for the vector ALU sequencer: opcode encoding and classes,
// chunk geometry and the sequencer state encoding.
package valu_seq_pkg;

  localparam int INT8    = 8;
  localparam int VLANES  = 16;
  localparam int CHUNK_W = VLANES * INT8;

  typedef enum logic [3:0] {
    OP_ADDSS = 4'h0,
    OP_SUBSS = 4'h1,
    OP_MULSS = 4'h2,
    OP_ADDVV = 4'h4,
    OP_SUBVV = 4'h5,
    OP_ADDVS = 4'h6,
    OP_SUBVS = 4'h7,
    OP_MULVS = 4'h8,
    OP_RELU  = 4'h9
  } op_code_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EX   = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic is_vv(input logic [3:0] op);
    return (op == OP_ADDVV) || (op == OP_SUBVV);
  endfunction

  function automatic logic is_vs(input logic [3:0] op);
    return (op == OP_ADDVS) || (op == OP_SUBVS) || (op == OP_MULVS);
  endfunction

  // relu is unary: it belongs to neither the vv nor the vs class but is legal.
  function automatic logic is_vec_legal(input logic [3:0] op);
    return is_vv(op) || is_vs(op) || (op == OP_RELU);
  endfunction

endpackage

// File: rtl/valu_seq.sv
// Chunk-by-chunk sequencer: RD -> EX -> WB per chunk, then a one-cycle DONE.
// The combinational vALU and the scratchpad live outside this block.
module valu_seq
  import valu_seq_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int LANES  = VLANES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_aluop,
  input  logic [31:0]           cmd_scalar,
  input  logic [ADDR_W-1:0]     cmd_src_a,
  input  logic [ADDR_W-1:0]     cmd_src_b,
  input  logic [ADDR_W-1:0]     cmd_dst,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  rd_en_a,
  output logic                  rd_en_b,
  output logic [ADDR_W-1:0]     rd_addr_a,
  output logic [ADDR_W-1:0]     rd_addr_b,
  input  logic [LANES*8-1:0]    rd_data_a,
  input  logic [LANES*8-1:0]    rd_data_b,
  output logic [3:0]            alu_op,
  output logic [LANES*8-1:0]    alu_in_a,
  output logic [LANES*8-1:0]    alu_in_b,
  output logic [31:0]           alu_in_s,
  input  logic [LANES*8-1:0]    alu_result,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [LANES*8-1:0]    wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = LANES * INT8;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [3:0]          op_q, op_d;
  logic [31:0]         scalar_q, scalar_d;
  logic [ADDR_W-1:0]   src_a_q, src_a_d;
  logic [ADDR_W-1:0]   src_b_q, src_b_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [CW-1:0]       result_q, result_d;
  logic                err_q, err_d;

  logic                last_chunk;
  logic [ADDR_W-1:0]   idx_addr;

  assign idx_addr   = ADDR_W'(idx_q);
  assign last_chunk = (idx_q == len_q - LEN_W'(1));

  // Next-state logic.
  // NOTE: every variable gets its default first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    op_d     = op_q;
    scalar_d = scalar_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    dst_d    = dst_q;
    result_d = result_q;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!is_vec_legal(cmd_aluop)) begin
            // Rejected commands leave the latched context untouched.
            err_d = 1'b1;
          end else begin
            op_d     = cmd_aluop;
            scalar_d = cmd_scalar;
            src_a_d  = cmd_src_a;
            src_b_d  = cmd_src_b;
            dst_d    = cmd_dst;
            len_d    = cmd_len;
            idx_d    = '0;
            state_d  = (cmd_len == '0) ? S_DONE : S_RD;
          end
        end
      end
      S_RD: state_d = S_EX;
      S_EX: begin
        result_d = alu_result;
        state_d  = S_WB;
      end
      S_WB: begin
        if (wr_ready) begin
          if (last_chunk) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = S_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      op_q     <= '0;
      scalar_q <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      op_q     <= op_d;
      scalar_q <= scalar_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      dst_q    <= dst_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Strobes and addresses decode straight from the state register, so an
  // asynchronous reset silences them in the same instant.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = err_q;

    rd_en_a   = (state_q == S_RD);
    rd_en_b   = (state_q == S_RD) && is_vv(op_q);
    rd_addr_a = (state_q == S_RD) ? src_a_q + idx_addr : '0;
    rd_addr_b = (state_q == S_RD) ? src_b_q + idx_addr : '0;

    alu_op    = op_q;
    alu_in_s  = scalar_q;
    alu_in_a  = (state_q == S_EX) ? rd_data_a : '0;
    alu_in_b  = ((state_q == S_EX) && is_vv(op_q)) ? rd_data_b : '0;

    wr_en     = (state_q == S_WB);
    wr_addr   = (state_q == S_WB) ? dst_q + idx_addr : '0;
    wr_data   = result_q;
  end

endmodule

// File: tb/tb_valu_seq.sv
// Self-checking bench for valu_seq: scratchpad and vALU behaviour modelled here,
// expected writes derived from a sequential read-compute-write reference.
module tb_valu_seq;
  import valu_seq_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_aluop = '0;
  logic [31:0]  cmd_scalar = '0;
  logic [7:0]   cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0, cmd_len = '0;
  logic         rd_en_a, rd_en_b;
  logic [7:0]   rd_addr_a, rd_addr_b;
  logic [127:0] rd_data_a = '0, rd_data_b = '0;
  logic [3:0]   alu_op;
  logic [127:0] alu_in_a, alu_in_b, alu_result;
  logic [31:0]  alu_in_s;
  logic         wr_en;
  logic [7:0]   wr_addr;
  logic [127:0] wr_data;
  logic         wr_ready = 1'b1;
  logic         busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] mem [256];

  typedef struct {
    logic [7:0]   ra, rb, wa;
    logic [127:0] a, b, r;
  } step_t;

  valu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_aluop(cmd_aluop),
    .cmd_scalar(cmd_scalar), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .alu_op(alu_op), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_in_s(alu_in_s),
    .alu_result(alu_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lane_op(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] s);
    case (op)
      OP_ADDVV: return a + b;
      OP_SUBVV: return a - b;
      OP_ADDVS: return a + s;
      OP_SUBVS: return a - s;
      OP_MULVS: return 8'(a * s);
      OP_RELU:  return a[7] ? 8'h00 : a;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] chunk_op(input logic [3:0] op, input logic [127:0] a,
                                            input logic [127:0] b, input logic [31:0] s);
    logic [127:0] r;
    for (int l = 0; l < 16; l++) r[l*8 +: 8] = lane_op(op, a[l*8 +: 8], b[l*8 +: 8], s[7:0]);
    return r;
  endfunction

  function automatic logic [127:0] splat(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic bit op_vv(input logic [3:0] op);
    return (op == OP_ADDVV) || (op == OP_SUBVV);
  endfunction

  // Scratchpad: one-cycle registered read; the vALU is purely combinational.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= mem[rd_addr_a];
    if (rd_en_b) rd_data_b <= mem[rd_addr_b];
  end

  always_comb alu_result = chunk_op(alu_op, alu_in_a, alu_in_b, alu_in_s);

  task automatic run_cmd(input logic [3:0] op, input logic [31:0] s,
                         input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] d,
                         input logic [7:0] len, input int stall_first, input bit rand_stall,
                         input bit poke_busy, input int abort_rd, input int exp_done);
    step_t        exp_q[$];
    step_t        st;
    logic [127:0] shadow [256];
    int rd_cnt = 0, rdb_cnt = 0, wr_cnt = 0, stalls = 0, stall_left = stall_first;
    int done_cyc = -1;
    bit prev_rd = 0;
    // Reference: each chunk reads current contents, then writes, in order.
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    for (int i = 0; i < int'(len); i++) begin
      st.ra = sa + 8'(i); st.rb = sb + 8'(i); st.wa = d + 8'(i);
      st.a = shadow[st.ra];
      st.b = op_vv(op) ? shadow[st.rb] : '0;
      st.r = chunk_op(op, st.a, st.b, s);
      shadow[st.wa] = st.r;
      exp_q.push_back(st);
    end

    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_aluop = op; cmd_scalar = s; cmd_src_a = sa; cmd_src_b = sb; cmd_dst = d; cmd_len = len;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = poke_busy;
    if (poke_busy) begin
      cmd_aluop = OP_ADDVS; cmd_dst = d + 8'd100; cmd_len = 8'd1;
    end

    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (poke_busy && !done) check("ready_busy", cmd_ready, 0);
      if (prev_rd) begin
        st = exp_q[0];
        check("ex_in_a", alu_in_a, st.a);
        check("ex_in_b", alu_in_b, st.b);
        check("ex_op", alu_op, op);
        check("ex_in_s", alu_in_s, s);
      end
      if (rd_en_a) begin
        rd_cnt++;
        if (rd_cnt == abort_rd) begin
          rst_n = 1'b0;
          cmd_valid = 1'b0;
          #1;
          check("rst_rd_en", {rd_en_a, rd_en_b, wr_en, busy, done, err}, 0);
          check("rst_addrs", {rd_addr_a, rd_addr_b, wr_addr}, 0);
          check("rst_alu", {alu_op, alu_in_s}, 0);
          check("rst_alu_in", alu_in_a | alu_in_b, 0);
          check("rst_wr_count", wr_cnt, rd_cnt - 1);
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
          repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", {wr_en, rd_en_a, busy}, 0);
            check("post_rst_ready", cmd_ready, 1);
          end
          return;
        end
        st = exp_q[0];
        check("rd_addr_a", rd_addr_a, st.ra);
        check("rd_en_b", rd_en_b, op_vv(op));
        if (op_vv(op)) check("rd_addr_b", rd_addr_b, st.rb);
      end
      if (rd_en_b) rdb_cnt++;
      prev_rd = rd_en_a;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wr", wr_addr, 8'hxx);
        end else begin
          st = exp_q[0];
          check("wr_addr", wr_addr, st.wa);
          check("wr_data", wr_data, st.r);
        end
        if (stall_left > 0 || (rand_stall && $urandom_range(2) == 0)) begin
          wr_ready = 1'b0;
          stalls++;
          if (stall_left > 0) stall_left--;
        end else begin
          wr_ready = 1'b1;
          if (exp_q.size() != 0) begin
            mem[st.wa] = st.r;
            void'(exp_q.pop_front());
          end
          wr_cnt++;
        end
      end else begin
        wr_ready = 1'b1;
      end
      if (done) begin
        done_cyc = k;
        cmd_valid = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
    check("done_cycle", done_cyc, (exp_done >= 0) ? exp_done : 3 * int'(len) + 1 + stalls);
    check("rd_count", rd_cnt, len);
    check("rdb_count", rdb_cnt, op_vv(op) ? int'(len) : 0);
    check("wr_count", wr_cnt, len);
    @(negedge clk);
    check("after_done", {done, busy, cmd_ready, err}, 4'b0010);
  endtask

  initial begin
    logic [3:0] legal_ops [6];
    legal_ops = '{OP_ADDVV, OP_SUBVV, OP_ADDVS, OP_SUBVS, OP_MULVS, OP_RELU};
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

    #2;
    check("reset_outs", {cmd_ready, busy, done, err, rd_en_a, rd_en_b, wr_en}, 7'b1000000);
    check("reset_addrs", {rd_addr_a, rd_addr_b, wr_addr, alu_op, alu_in_s}, 0);
    check("reset_data", alu_in_a | alu_in_b | wr_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // mulvs x3 over two chunks of 0x05.
    mem[8'h10] = splat(8'h05); mem[8'h11] = splat(8'h05);
    run_cmd(OP_MULVS, 32'h3, 8'h10, 8'h40, 8'h20, 8'd2, 0, 0, 0, 0, 7);
    check("mulvs_mem0", mem[8'h20], splat(8'h0F));
    check("mulvs_mem1", mem[8'h21], splat(8'h0F));

    // addvv single chunk.
    mem[8'h30] = splat(8'h05); mem[8'h31] = splat(8'h03);
    run_cmd(OP_ADDVV, 32'h0, 8'h30, 8'h31, 8'h32, 8'd1, 0, 0, 0, 0, 4);
    check("addvv_mem", mem[8'h32], splat(8'h08));

    // relu on alternating negative/positive lanes.
    mem[8'h50] = {8{16'h8505}};
    run_cmd(OP_RELU, 32'h0, 8'h50, 8'h00, 8'h51, 8'd1, 0, 0, 0, 0, 4);
    check("relu_mem", mem[8'h51], {8{16'h0005}});

    // Zero-length command.
    run_cmd(OP_SUBVS, 32'h7, 8'h00, 8'h00, 8'h60, 8'd0, 0, 0, 0, 0, 1);

    // Illegal opcode: err pulse, no activity.
    @(negedge clk);
    cmd_aluop = OP_MULSS; cmd_len = 8'd2; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("illegal_err", err, 1);
    check("illegal_quiet", {cmd_ready, busy, rd_en_a, wr_en, done}, 5'b10000);
    @(negedge clk);
    check("illegal_err_once", {err, busy}, 0);

    // Stalled first write-back and a second command offered while busy.
    run_cmd(OP_ADDVV, 32'h0, 8'h70, 8'h78, 8'h80, 8'd2, 3, 0, 1, 0, 10);

    // Destination wraps past the top of the address space.
    run_cmd(OP_ADDVS, 32'h11, 8'h90, 8'h00, 8'hFF, 8'd2, 0, 0, 0, 0, 7);

    // Reset during the second RD of a wrapping command.
    mem[8'h00] = splat(8'hAA);
    run_cmd(OP_SUBVS, 32'h01, 8'hA0, 8'h00, 8'hFF, 8'd2, 0, 0, 0, 2, -1);
    check("rst_no_second_wr", mem[8'h00], splat(8'hAA));

    // Randomized commands with overlapping regions and random stalls.
    for (int t = 0; t < 24; t++) begin
      run_cmd(legal_ops[$urandom_range(5)], $urandom, 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom_range(5)), 0, 1, 0, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
